// File: rtl/sdram_refresh_arbiter.sv
// SDRAM power-up init sequencer and refresh/CPU arbiter.
// Optional macro REFRESH_BURST_EN chains owed refreshes without revisiting IDLE.
module sdram_refresh_arbiter #(
  parameter int INIT_WAIT        = 5000,
  parameter int INIT_REFRESHES   = 8,
  parameter int REFRESH_INTERVAL = 390,
  parameter int MAX_PENDING      = 8,
  parameter int URGENT_THRESH    = 4
) (
  input  logic       MEMCLK,
  input  logic       RESET_n,
  input  logic       cpu_req,
  input  logic       cpu_done,
  input  logic       cmd_done,
  output logic       cpu_grant,
  output logic       op_start,
  output logic [1:0] op_code,
  output logic       init_done,
  output logic [3:0] ref_pending,
  output logic       ref_overflow
);

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_PRE = 2'b01;
  localparam logic [1:0] OP_REF = 2'b10;
  localparam logic [1:0] OP_MRS = 2'b11;

  localparam int WAIT_W = $clog2(INIT_WAIT + 1);
  localparam int TMR_W  = $clog2(REFRESH_INTERVAL + 1);
  localparam int IREF_W = $clog2(INIT_REFRESHES + 1);

  typedef enum logic [2:0] {
    S_INIT_WAIT, S_INIT_PRE, S_INIT_REF, S_INIT_MRS, S_IDLE, S_CPU, S_REF
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [TMR_W-1:0]  ref_timer;
  logic [IREF_W-1:0] init_ref_cnt;
  logic              tick;
  logic              ref_dec;
  logic              burst_next;
  logic [3:0]        pending_next;

  assign tick    = init_done && (ref_timer == TMR_W'(REFRESH_INTERVAL - 1));
  assign ref_dec = (state == S_REF) && cmd_done;

  // A tick and a completed refresh in the same cycle cancel out.
  always_comb begin
    pending_next = ref_pending;
    if (tick && !ref_dec) begin
      if (ref_pending != 4'(MAX_PENDING))
        pending_next = ref_pending + 4'd1;
    end else if (ref_dec && !tick) begin
      pending_next = ref_pending - 4'd1;
    end
  end

`ifdef REFRESH_BURST_EN
  assign burst_next = (pending_next != 4'd0) &&
                      (!cpu_req || (pending_next >= 4'(URGENT_THRESH)));
`else
  assign burst_next = 1'b0;
`endif

  always_ff @(posedge MEMCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      ref_timer    <= '0;
      ref_pending  <= 4'd0;
      ref_overflow <= 1'b0;
    end else begin
      if (init_done)
        ref_timer <= tick ? '0 : ref_timer + 1'b1;
      ref_pending <= pending_next;
      if (tick && (ref_pending == 4'(MAX_PENDING)))
        ref_overflow <= 1'b1;
    end
  end

  always_ff @(posedge MEMCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state        <= S_INIT_WAIT;
      wait_cnt     <= '0;
      init_ref_cnt <= '0;
      cpu_grant    <= 1'b0;
      op_start     <= 1'b0;
      op_code      <= OP_NOP;
      init_done    <= 1'b0;
    end else begin
      op_start <= 1'b0;
      case (state)
        S_INIT_WAIT: begin
          if (wait_cnt == WAIT_W'(INIT_WAIT - 1)) begin
            state    <= S_INIT_PRE;
            op_start <= 1'b1;
            op_code  <= OP_PRE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_INIT_PRE: begin
          if (cmd_done) begin
            state        <= S_INIT_REF;
            op_start     <= 1'b1;
            op_code      <= OP_REF;
            init_ref_cnt <= '0;
          end
        end
        S_INIT_REF: begin
          if (cmd_done) begin
            op_start <= 1'b1;
            if (init_ref_cnt == IREF_W'(INIT_REFRESHES - 1)) begin
              state   <= S_INIT_MRS;
              op_code <= OP_MRS;
            end else begin
              init_ref_cnt <= init_ref_cnt + 1'b1;
            end
          end
        end
        S_INIT_MRS: begin
          if (cmd_done) begin
            state     <= S_IDLE;
            op_code   <= OP_NOP;
            init_done <= 1'b1;
          end
        end
        // Urgent backlog beats the CPU; otherwise the CPU beats a small backlog.
        S_IDLE: begin
          if (ref_pending >= 4'(URGENT_THRESH)) begin
            state    <= S_REF;
            op_start <= 1'b1;
            op_code  <= OP_REF;
          end else if (cpu_req) begin
            state     <= S_CPU;
            cpu_grant <= 1'b1;
          end else if (ref_pending != 4'd0) begin
            state    <= S_REF;
            op_start <= 1'b1;
            op_code  <= OP_REF;
          end
        end
        S_CPU: begin
          if (cpu_done) begin
            state     <= S_IDLE;
            cpu_grant <= 1'b0;
          end
        end
        S_REF: begin
          if (cmd_done) begin
            if (burst_next) begin
              op_start <= 1'b1;
            end else begin
              state   <= S_IDLE;
              op_code <= OP_NOP;
            end
          end
        end
        default: begin
          state     <= S_INIT_WAIT;
          cpu_grant <= 1'b0;
          op_code   <= OP_NOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_refresh_arbiter.sv
// Randomized scoreboard bench for sdram_refresh_arbiter against a queue-based reference model.
// Honours REFRESH_BURST_EN when the design is built with it.
module tb_sdram_refresh_arbiter;

  localparam int P_INIT_WAIT        = 20;
  localparam int P_INIT_REFRESHES   = 2;
  localparam int P_REFRESH_INTERVAL = 16;
  localparam int P_MAX_PENDING      = 8;
  localparam int P_URGENT_THRESH    = 4;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_PRE = 2'b01;
  localparam logic [1:0] OP_REF = 2'b10;
  localparam logic [1:0] OP_MRS = 2'b11;

  localparam logic [2:0] EV_OPSTART   = 3'd1;
  localparam logic [2:0] EV_GRANT_ON  = 3'd2;
  localparam logic [2:0] EV_GRANT_OFF = 3'd3;
  localparam logic [2:0] EV_INIT_DONE = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] cyc;
    logic [1:0]  code;
    logic [3:0]  pending;
    logic        ovf;
  } ev_t;

  logic       MEMCLK = 1'b0;
  logic       RESET_n = 1'b0;
  logic       cpu_req = 1'b0;
  logic       cpu_done = 1'b0;
  logic       cmd_done = 1'b0;
  logic       cpu_grant;
  logic       op_start;
  logic [1:0] op_code;
  logic       init_done;
  logic [3:0] ref_pending;
  logic       ref_overflow;

  ev_t exp_q[$];
  int  checks = 0;
  int  passes = 0;
  int  cyc = 0;

  bit  seq_busy;
  int  seq_wait;
  int  hold_left;

  int         m_edges;
  int         m_init_edge;
  int         m_pending;
  int         m_next_cyc;
  bit         m_init_done;
  bit         m_overflow;
  bit         m_op_active;
  bit         m_grant;
  logic [1:0] m_init_ops[$];

  logic prev_grant = 1'b0;
  logic prev_init = 1'b0;

  sdram_refresh_arbiter #(
    .INIT_WAIT        (P_INIT_WAIT),
    .INIT_REFRESHES   (P_INIT_REFRESHES),
    .REFRESH_INTERVAL (P_REFRESH_INTERVAL),
    .MAX_PENDING      (P_MAX_PENDING),
    .URGENT_THRESH    (P_URGENT_THRESH)
  ) dut (
    .MEMCLK       (MEMCLK),
    .RESET_n      (RESET_n),
    .cpu_req      (cpu_req),
    .cpu_done     (cpu_done),
    .cmd_done     (cmd_done),
    .cpu_grant    (cpu_grant),
    .op_start     (op_start),
    .op_code      (op_code),
    .init_done    (init_done),
    .ref_pending  (ref_pending),
    .ref_overflow (ref_overflow)
  );

  always #5 MEMCLK = ~MEMCLK;

  always @(posedge MEMCLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic pushEvent(input logic [2:0] kind, input logic [1:0] code);
    ev_t ev;
    ev.kind    = kind;
    ev.cyc     = 32'(m_next_cyc);
    ev.code    = code;
    ev.pending = 4'(m_pending);
    ev.ovf     = m_overflow;
    exp_q.push_back(ev);
  endtask

  task automatic modelIssue(input logic [1:0] code);
    m_op_active = 1'b1;
    pushEvent(EV_OPSTART, code);
  endtask

  task automatic modelReset();
    m_edges = 0; m_init_edge = 0; m_pending = 0; m_next_cyc = 0;
    m_init_done = 0; m_overflow = 0; m_op_active = 0; m_grant = 0;
    m_init_ops.delete();
    for (int i = 0; i < P_INIT_REFRESHES; i++) m_init_ops.push_back(OP_REF);
    m_init_ops.push_back(OP_MRS);
    exp_q.delete();
  endtask

  // Reference model: one call per clock edge, with the inputs the edge will sample.
  task automatic modelStep(input bit req, input bit cdone, input bit kdone);
    int old_p;
    bit tick;
    bit dec;
    m_edges++;
    m_next_cyc = cyc + 1;
    old_p = m_pending;
    tick = m_init_done && (((m_edges - m_init_edge) % P_REFRESH_INTERVAL) == 0);
    dec  = m_init_done && m_op_active && kdone;
    if (tick && old_p == P_MAX_PENDING) m_overflow = 1'b1;
    if (tick && !dec) m_pending = (old_p < P_MAX_PENDING) ? old_p + 1 : old_p;
    else if (dec && !tick) m_pending = old_p - 1;

    if (!m_init_done) begin
      if (!m_op_active) begin
        if (m_edges == P_INIT_WAIT) modelIssue(OP_PRE);
      end else if (kdone) begin
        if (m_init_ops.size() > 0) begin
          modelIssue(m_init_ops.pop_front());
        end else begin
          m_op_active = 1'b0;
          m_init_done = 1'b1;
          m_init_edge = m_edges;
          pushEvent(EV_INIT_DONE, OP_NOP);
        end
      end
    end else if (m_grant) begin
      if (cdone) begin
        m_grant = 1'b0;
        pushEvent(EV_GRANT_OFF, OP_NOP);
      end
    end else if (m_op_active) begin
      if (kdone) begin
        m_op_active = 1'b0;
`ifdef REFRESH_BURST_EN
        if (m_pending > 0 && (!req || m_pending >= P_URGENT_THRESH)) modelIssue(OP_REF);
`endif
      end
    end else begin
      if (old_p >= P_URGENT_THRESH) modelIssue(OP_REF);
      else if (req) begin
        m_grant = 1'b1;
        pushEvent(EV_GRANT_ON, OP_NOP);
      end else if (old_p > 0) modelIssue(OP_REF);
    end
  endtask

  task automatic monitorEvent(input logic [2:0] kind);
    ev_t act;
    ev_t exp;
    act.kind    = kind;
    act.cyc     = 32'(cyc);
    act.code    = op_code;
    act.pending = ref_pending;
    act.ovf     = ref_overflow;
    if (exp_q.size() == 0) begin
      checkOutput("unexpected_event", 64'(act), 64'd0);
    end else begin
      exp = exp_q.pop_front();
      checkOutput("event", 64'(act), 64'(exp));
    end
  endtask

  // Monitor: turns visible DUT activity into events and checks them against the queue.
  always @(posedge MEMCLK) begin
    #1;
    if (!RESET_n) begin
      prev_grant = 1'b0;
      prev_init  = 1'b0;
    end else begin
      if (init_done && !prev_init) monitorEvent(EV_INIT_DONE);
      if (!cpu_grant && prev_grant) monitorEvent(EV_GRANT_OFF);
      if (cpu_grant && !prev_grant) monitorEvent(EV_GRANT_ON);
      if (op_start) monitorEvent(EV_OPSTART);
      prev_grant = cpu_grant;
      prev_init  = init_done;
    end
  end

  // Each cycle (entered at a falling edge) emulates the sequencer and the CPU requester.
  task automatic applyStimulus(input int n, input int req_pct, input int hmin, input int hmax);
    repeat (n) begin
      cmd_done = 1'b0;
      cpu_done = 1'b0;
      if (op_start) begin
        seq_busy = 1'b1;
        seq_wait = $urandom_range(0, 3);
      end
      if (seq_busy) begin
        if (seq_wait == 0) begin
          cmd_done = 1'b1;
          seq_busy = 1'b0;
        end else seq_wait--;
      end else if ($urandom_range(0, 99) < 3) cmd_done = 1'b1;
      if (cpu_req && cpu_grant) begin
        if (hold_left == 0) begin
          cpu_done = 1'b1;
          cpu_req  = 1'b0;
        end else hold_left--;
      end else if (!cpu_req) begin
        if ($urandom_range(0, 99) < req_pct) begin
          cpu_req   = 1'b1;
          hold_left = $urandom_range(hmin, hmax);
        end else if (!cpu_grant && $urandom_range(0, 99) < 3) cpu_done = 1'b1;
      end
      modelStep(cpu_req, cpu_done, cmd_done);
      @(posedge MEMCLK);
      @(negedge MEMCLK);
    end
  endtask

  task automatic resetDut();
    RESET_n  = 1'b0;
    cpu_req  = 1'b0;
    cpu_done = 1'b0;
    cmd_done = 1'b0;
    seq_busy = 1'b0;
    seq_wait = 0;
    hold_left = 0;
    modelReset();
    #1;
    checkOutput("reset_outputs",
                64'({cpu_grant, op_start, op_code, init_done, ref_pending, ref_overflow}), 64'd0);
    repeat (3) @(negedge MEMCLK);
    RESET_n = 1'b1;
  endtask

  task automatic resetMidRef();
    int waited = 0;
    while (!(op_code == OP_REF && init_done) && waited < 200) begin
      applyStimulus(1, 0, 1, 1);
      waited++;
    end
    checkOutput("ref_in_flight", 64'({op_code, init_done}), 64'({OP_REF, 1'b1}));
    checkOutput("queue_before_reset", 64'(exp_q.size()), 64'd0);
    resetDut();
  endtask

  initial begin
    @(negedge MEMCLK);
    resetDut();
    applyStimulus(60, 100, 1, 6);
    applyStimulus(100, 0, 1, 1);
    checkOutput("idle_pending", 64'(ref_pending), 64'(m_pending));
    applyStimulus(1, 100, 80, 80);
    applyStimulus(160, 0, 1, 1);
    checkOutput("no_overflow_80", 64'(ref_overflow), 64'd0);
    applyStimulus(1, 100, 150, 150);
    applyStimulus(250, 0, 1, 1);
    checkOutput("overflow_sticky", 64'(ref_overflow), 64'd1);
    checkOutput("drained_pending", 64'(ref_pending), 64'(m_pending));
    applyStimulus(1500, 30, 0, 40);
    checkOutput("overflow_still_set", 64'(ref_overflow), 64'd1);
    resetMidRef();
    applyStimulus(60, 50, 0, 10);
    checkOutput("overflow_cleared", 64'(ref_overflow), 64'd0);
    applyStimulus(600, 20, 0, 60);
    checkOutput("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
